// File: rtl/fifo_rd_stream_adapter.sv
// Drains a synchronous FIFO read port into a valid/ready stream, hiding the
// FIFO's one-cycle read latency behind a 2-entry skid buffer; counts delivered words.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [CNT_WIDTH-1:0]  r_xfer_count;

  logic                  w_pop;
  logic [1:0]            w_occ_next;
  logic                  w_rd_ptr_next;
  logic [DATA_WIDTH-1:0] w_head_next;

  assign w_pop         = r_m_valid && m_ready;
  assign w_occ_next    = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_rd_ptr_next = r_rd_ptr ^ w_pop;

  // A read may only issue if its word is guaranteed a free slot when it lands.
  assign fifo_r_en = !rst_n && !fifo_empty && (w_occ_next < 2'd2);

  // The word landing this cycle becomes the head when it is written to the slot the read pointer moves to.
  assign w_head_next = (r_inflight && (r_wr_ptr == w_rd_ptr_next)) ? fifo_data_out
                                                                   : r_buf[w_rd_ptr_next];

  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_buf[r_wr_ptr] <= fifo_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_xfer_count <= '0;
    end else begin
      r_occ        <= w_occ_next;
      r_inflight   <= fifo_r_en;
      r_wr_ptr     <= r_wr_ptr ^ r_inflight;
      r_rd_ptr     <= w_rd_ptr_next;
      r_m_valid    <= (w_occ_next != 2'd0);
      if (w_occ_next != 2'd0) begin
        r_m_data <= w_head_next;
      end
      r_xfer_count <= r_xfer_count + {{(CNT_WIDTH-1){1'b0}}, w_pop};
    end
  end

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural FIFO in front, scoreboard of
// words the FIFO hands out, checked in order as the stream delivers them.
module tb_fifo_rd_stream_adapter;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_r_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] xfer_count;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_r_en    (fifo_r_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .xfer_count   (xfer_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural synchronous FIFO: registered read data, reset with the adapter.
  logic [7:0] mem [256];
  int         fifo_wr = 0;
  int         fifo_rd = 0;
  assign fifo_empty = (fifo_wr == fifo_rd);

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fifo_rd       <= 0;
      fifo_data_out <= '0;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_data_out <= mem[fifo_rd[7:0]];
      fifo_rd       <= fifo_rd + 1;
    end
  end

  // Monitor: scoreboard push on accepted reads, pop/compare on stream transfers.
  logic [7:0]    sb_q [$];
  int            ren_cnt = 0;
  int            pop_cnt = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [CW-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      sb_q.delete();
      hold_prev = 1'b0;
      exp_cnt   = '0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      if (fifo_r_en) begin
        ren_cnt++;
        chk("ren_empty", fifo_empty, 0);
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        chk("cnt", xfer_count, exp_cnt);
        exp_cnt++;
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("order", m_data, sb_q.pop_front());
      end
      if (fifo_r_en && !fifo_empty) sb_q.push_back(mem[fifo_rd[7:0]]);
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) mem[(fifo_wr + i) & 255] = base + 8'(i);
    fifo_wr += n;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  b;
    int  d;
    bit  done;
    bit  seen_first;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    load(8, 8'h01);
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_ren", fifo_r_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cnt", xfer_count, 0);

    // Streaming with the sink always ready
    cyc();
    rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stream_ren", fifo_r_en, (c < 8) ? 1 : 0);
      if (c >= 2) begin
        chk("stream_valid", m_valid, 1);
        chk("stream_data", m_data, c - 1);
      end
    end
    @(negedge clk);
    chk("stream_idle", m_valid, 0);
    chk("stream_cnt", xfer_count, 8);

    // Backpressure: only two reads may be outstanding or buffered
    cyc();
    m_ready = 1'b0;
    b = ren_cnt;
    load(5, 8'h11);
    repeat (8) cyc();
    chk("bp_ren", ren_cnt - b, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h11);
    m_ready = 1'b1;
    b = pop_cnt;
    repeat (5) @(negedge clk);
    cyc();
    chk("bp_pops", pop_cnt - b, 5);
    chk("bp_drained", m_valid, 0);

    // Alternating sink readiness
    b = pop_cnt;
    load(6, 8'hA0);
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      cyc();
    end
    m_ready = 1'b1;
    repeat (3) cyc();
    chk("alt_pops", pop_cnt - b, 6);
    chk("alt_sb", sb_q.size(), 0);

    // Reset while the buffer is full
    m_ready = 1'b0;
    load(4, 8'h51);
    repeat (6) cyc();
    chk("mr_valid_pre", m_valid, 1);
    @(posedge clk);
    #4;
    rst_n   = 1'b1;
    fifo_wr = 0;
    #1;
    chk("mr_valid", m_valid, 0);
    chk("mr_data", m_data, 0);
    chk("mr_cnt", xfer_count, 0);
    chk("mr_ren", fifo_r_en, 0);
    repeat (2) cyc();

    // Resume from empty and run the counter through its wrap
    load(17, 8'h40);
    m_ready    = 1'b1;
    rst_n      = 1'b0;
    b          = pop_cnt;
    d          = 0;
    done       = 1'b0;
    seen_first = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      #1;
      d = pop_cnt - b;
      if (m_valid && !seen_first) begin
        seen_first = 1'b1;
        chk("mr_first", m_data, 8'h40);
      end
      if (d == 15) chk("wrap15", xfer_count, 15);
      if (d == 16) chk("wrap16", xfer_count, 0);
      if (d == 17) begin
        chk("wrap17", xfer_count, 1);
        done = 1'b1;
      end
    end
    if (!done) chk("wrap_timeout", d, 17);
    repeat (3) cyc();
    chk("end_sb", sb_q.size(), 0);
    chk("end_valid", m_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
